// File: rtl/traffic_analyzer_gmii_rx_stats_if.sv
// GMII receive bus bundle: the PHY side drives it, the analyzer samples it.
interface traffic_analyzer_gmii_rx_stats_if;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;

  modport master (output gmii_rxd, output gmii_rx_dv, output gmii_rx_er);
  modport slave  (input  gmii_rxd, input  gmii_rx_dv, input  gmii_rx_er);
endinterface

// File: rtl/traffic_analyzer_gmii_rx_stats.sv
// GMII receive analysis core: frame delineation, CRC check, good/bad/idle
// statistics, SFD timestamping and a double-banked capture of the last frame.
module traffic_analyzer_gmii_rx_stats #(
  parameter int BUF_AW = 8,
  parameter int CNT_W  = 64
) (
  input  logic                            clk,
  input  logic                            resetn,
  traffic_analyzer_gmii_rx_stats_if.slave i_gmii,
  input  logic                            i_enable,
  input  logic [63:0]                     i_ts_sec,
  input  logic [31:0]                     i_ts_nsec,
  input  logic [BUF_AW-1:0]               i_frame_buf_address,
  output logic [31:0]                     o_frame_buf_data,
  output logic [CNT_W-1:0]                o_pkts,
  output logic [CNT_W-1:0]                o_octets,
  output logic [CNT_W-1:0]                o_bad_crc_pkts,
  output logic [CNT_W-1:0]                o_bad_crc_octets,
  output logic [CNT_W-1:0]                o_octets_idle,
  output logic [63:0]                     o_timestamp_sec,
  output logic [31:0]                     o_timestamp_nsec,
  output logic [31:0]                     o_frame_size
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_EOF      = 3'd3;
  localparam logic [2:0] S_DISCARD  = 3'd4;

  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam int          DEPTH       = 1 << BUF_AW;

  // Input sampling stage
  logic [7:0]  r_rxd;
  logic        r_dv;
  logic        r_er;
  logic        r_en;
  logic [63:0] r_tsSec;
  logic [31:0] r_tsNsec;

  // Frame tracking
  logic [2:0]  r_state;
  logic [31:0] r_len;
  logic [31:0] r_crc;
  logic        r_errSeen;
  logic        r_frameEn;
  logic [63:0] r_sfdSec;
  logic [31:0] r_sfdNsec;
  logic [31:0] r_word;
  logic        r_wbank;

  // Statistics and CPU view
  logic [CNT_W-1:0] r_pkts;
  logic [CNT_W-1:0] r_octets;
  logic [CNT_W-1:0] r_badPkts;
  logic [CNT_W-1:0] r_badOctets;
  logic [CNT_W-1:0] r_idle;
  logic [63:0]      r_tsOutSec;
  logic [31:0]      r_tsOutNsec;
  logic [31:0]      r_frameSize;
  logic [31:0]      r_rdData;
  logic [31:0]      r_mem [0:2*DEPTH-1];

  logic [31:0]       w_crcNext;
  logic [31:0]       w_lenNext;
  logic [1:0]        w_lane;
  logic [31:0]       w_wordNext;
  logic              w_inRange;
  logic              w_sfd;
  logic              w_good;
  logic              w_memWe;
  logic [BUF_AW:0]   w_memAddr;
  logic [31:0]       w_memData;

  // Reflected CRC-32 update for one byte, LSB first
  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) begin
      x = (x >> 1) ^ (32'hEDB88320 & {32{x[0] ^ d[i]}});
    end
    return x;
  endfunction

  assign w_crcNext  = crcByte(r_crc, r_rxd);
  assign w_lenNext  = (r_len == 32'hFFFF_FFFF) ? r_len : r_len + 32'd1;
  assign w_lane     = r_len[1:0];
  assign w_wordNext = ((w_lane == 2'd0) ? 32'h0 : r_word) |
                      ({24'h0, r_rxd} << {2'd3 - w_lane, 3'b000});
  assign w_inRange  = (r_len[31:BUF_AW+2] == '0);
  assign w_sfd      = ((r_state == S_IDLE) || (r_state == S_EOF) || (r_state == S_PREAMBLE)) &&
                      r_dv && (r_rxd == SFD_BYTE);
  assign w_good     = (r_crc == CRC_RESIDUE) && !r_errSeen && (r_len >= 32'd4);

  // Register every input once; all decisions use these samples
  always_ff @(posedge clk) begin
    r_rxd    <= i_gmii.gmii_rxd;
    r_dv     <= i_gmii.gmii_rx_dv;
    r_er     <= i_gmii.gmii_rx_er;
    r_en     <= i_enable;
    r_tsSec  <= i_ts_sec;
    r_tsNsec <= i_ts_nsec;
  end

  // Frame delineation FSM; EOF also accepts the next frame's first byte
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_DISCARD;
      r_len     <= '0;
      r_crc     <= '1;
      r_errSeen <= 1'b0;
      r_frameEn <= 1'b0;
      r_sfdSec  <= '0;
      r_sfdNsec <= '0;
      r_word    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_EOF: begin
          if (!r_dv)                  r_state <= S_IDLE;
          else if (r_rxd == PRE_BYTE) r_state <= S_PREAMBLE;
          else if (r_rxd == SFD_BYTE) r_state <= S_DATA;
          else                        r_state <= S_DISCARD;
        end
        S_PREAMBLE: begin
          if (!r_dv)                  r_state <= S_IDLE;
          else if (r_rxd == SFD_BYTE) r_state <= S_DATA;
          else if (r_rxd != PRE_BYTE) r_state <= S_DISCARD;
        end
        S_DATA: begin
          if (!r_dv) begin
            r_state <= S_EOF;
          end else begin
            r_len  <= w_lenNext;
            r_crc  <= w_crcNext;
            r_word <= w_wordNext;
            if (r_er) r_errSeen <= 1'b1;
          end
        end
        S_DISCARD: begin
          if (!r_dv) r_state <= S_IDLE;
        end
        default: r_state <= S_DISCARD;
      endcase
      if (w_sfd) begin
        r_len     <= '0;
        r_crc     <= '1;
        r_errSeen <= 1'b0;
        r_word    <= '0;
        r_frameEn <= r_en;
        r_sfdSec  <= r_tsSec;
        r_sfdNsec <= r_tsNsec;
      end
    end
  end

  // Statistics, publication of the finished frame and capture bank swap
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pkts      <= '0;
      r_octets    <= '0;
      r_badPkts   <= '0;
      r_badOctets <= '0;
      r_idle      <= '0;
      r_tsOutSec  <= '0;
      r_tsOutNsec <= '0;
      r_frameSize <= '0;
      r_wbank     <= 1'b0;
    end else begin
      if (!r_dv && r_en) r_idle <= r_idle + CNT_W'(1);
      if ((r_state == S_EOF) && r_frameEn) begin
        if (w_good) begin
          r_pkts   <= r_pkts + CNT_W'(1);
          r_octets <= r_octets + CNT_W'(r_len);
        end else begin
          r_badPkts   <= r_badPkts + CNT_W'(1);
          r_badOctets <= r_badOctets + CNT_W'(r_len);
        end
        r_tsOutSec  <= r_sfdSec;
        r_tsOutNsec <= r_sfdNsec;
        r_frameSize <= r_len;
        r_wbank     <= ~r_wbank;
      end
    end
  end

  // Capture write: full word on its 4th byte, partial word at EOF
  always_comb begin
    w_memWe   = 1'b0;
    w_memAddr = '0;
    w_memData = '0;
    if (r_frameEn && w_inRange) begin
      if ((r_state == S_DATA) && r_dv && (w_lane == 2'd3)) begin
        w_memWe   = 1'b1;
        w_memAddr = {r_wbank, r_len[BUF_AW+1:2]};
        w_memData = w_wordNext;
      end else if ((r_state == S_EOF) && (w_lane != 2'd0)) begin
        w_memWe   = 1'b1;
        w_memAddr = {r_wbank, r_len[BUF_AW+1:2]};
        w_memData = r_word;
      end
    end
  end

  // Capture RAM write port
  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[w_memAddr] <= w_memData;
  end

  // CPU read port on the bank not being written
  always_ff @(posedge clk) begin
    if (!resetn) r_rdData <= '0;
    else         r_rdData <= r_mem[{~r_wbank, i_frame_buf_address}];
  end

  assign o_frame_buf_data = r_rdData;
  assign o_pkts           = r_pkts;
  assign o_octets         = r_octets;
  assign o_bad_crc_pkts   = r_badPkts;
  assign o_bad_crc_octets = r_badOctets;
  assign o_octets_idle    = r_idle;
  assign o_timestamp_sec  = r_tsOutSec;
  assign o_timestamp_nsec = r_tsOutNsec;
  assign o_frame_size     = r_frameSize;

endmodule
